btb_update_ctrl: RTL

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_update_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// BTB update controller: round-robin merge of decode/execute update requests
// through a small FIFO into BTB strobes. Optional flush walk under BTB_FLUSH_EN.
module btb_update_ctrl #(
  parameter int BTBNUM     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_req_valid,
  output logic        id_req_ready,
  input  logic [74:0] id_req_pkt,
  input  logic        ex_req_valid,
  output logic        ex_req_ready,
  input  logic [74:0] ex_req_pkt,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        operate_en,
  output logic        add_entry,
  output logic        delete_entry,
  output logic        target_error,
  output logic        pre_error,
  output logic        pre_right,
  output logic        right_orien,
  output logic        push_ras,
  output logic        pop_ras,
  output logic [31:0] operate_pc,
  output logic [4:0]  operate_index,
  output logic [31:0] right_target
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [74:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic          idle, walk;
  logic [4:0]    walk_idx;
  logic          last_ex;  // 1 = execute port won the last transfer
  logic          gnt_id, gnt_ex;
  logic [74:0]   head;

  assign full  = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;

  assign gnt_ex = ex_req_valid && (!id_req_valid || !last_ex);
  assign gnt_id = id_req_valid && (!ex_req_valid || last_ex);

  // resetn gating keeps ready low while reset is held with valids asserted
  assign id_req_ready = resetn && idle && !full && gnt_id;
  assign ex_req_ready = resetn && idle && !full && gnt_ex;

  assign push = (id_req_valid && id_req_ready) || (ex_req_valid && ex_req_ready);
  assign pop  = !empty && !walk;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_ex <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        last_ex <= gnt_ex;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gnt_ex ? ex_req_pkt : id_req_pkt;
  end

`ifdef BTB_FLUSH_EN
  typedef enum logic [1:0] {IDLE, DRAIN, WALK} state_t;
  state_t     state, state_nxt;
  logic [4:0] walk_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      walk_idx <= '0;
    end else begin
      state    <= state_nxt;
      walk_idx <= walk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    walk_nxt  = walk_idx;
    case (state)
      IDLE:  if (flush_req) state_nxt = DRAIN;
      DRAIN: if (empty) begin
        state_nxt = WALK;
        walk_nxt  = '0;
      end
      WALK: begin
        if (walk_idx == 5'(BTBNUM - 1)) begin
          state_nxt = IDLE;
          walk_nxt  = '0;
        end else begin
          walk_nxt = walk_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign idle       = state == IDLE;
  assign walk       = state == WALK;
  assign flush_busy = !idle;
`else
  localparam int unused_btbnum = BTBNUM;
  logic unused_flush_req;
  assign unused_flush_req = flush_req;
  assign idle       = 1'b1;
  assign walk       = 1'b0;
  assign walk_idx   = '0;
  assign flush_busy = 1'b0;
`endif

  always_comb begin
    operate_en    = 1'b0;
    add_entry     = 1'b0;
    delete_entry  = 1'b0;
    target_error  = 1'b0;
    pre_error     = 1'b0;
    pre_right     = 1'b0;
    right_orien   = 1'b0;
    push_ras      = 1'b0;
    pop_ras       = 1'b0;
    operate_pc    = '0;
    operate_index = '0;
    right_target  = '0;
    if (walk) begin
      operate_en    = 1'b1;
      delete_entry  = 1'b1;
      operate_index = walk_idx;
    end else if (pop) begin
      {right_orien, push_ras, pop_ras} = head[71:69];
      operate_index = head[68:64];
      operate_pc    = head[63:32];
      right_target  = head[31:0];
      // unknown op codes still pop, but never reach the BTB
      case (head[74:72])
        3'b001: begin operate_en = 1'b1; add_entry    = 1'b1; end
        3'b010: begin operate_en = 1'b1; delete_entry = 1'b1; end
        3'b011: begin operate_en = 1'b1; target_error = 1'b1; end
        3'b100: begin operate_en = 1'b1; pre_right    = 1'b1; end
        3'b101: begin operate_en = 1'b1; pre_error    = 1'b1; end
        default: operate_en = 1'b0;
      endcase
    end
  end
endmodule
